// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    RESP
  } arb_state_t;

  // Which requester owns the current (or most recent) bus transaction.
  typedef enum logic {
    G_FETCH,
    G_DATA
  } grant_t;

  // Bus size code used for every instruction fetch.
  localparam logic [2:0] XFER_WORD = 3'b010;

  // Width of the wait-state counter; TIMEOUT must fit below its saturation point.
  localparam int WAIT_W = 10;

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter for one bus transaction. Cleared at grant, counts bus
// cycles that end without mem_ack, and flags the cycle whose count would
// reach TIMEOUT so the arbiter can abort on that same edge.
module wait_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [WAIT_W-1:0] count,
  output logic              expire
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] count_reg;
  logic [WAIT_W-1:0] count_next;
  logic [WAIT_W-1:0] count_inc;

  // Saturating increment, clear priority, and the expiry flag for this cycle.
  always_comb begin
    count_inc  = (count_reg == '1) ? count_reg : count_reg + 1'b1;
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count_inc;
    end
    expire = enable & ~clear & (count_inc == LIMIT);
  end

  // Counter register.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and load/store.
// One transaction in flight at a time, round-robin on ties, wait-state
// timeout abort, registered one-cycle completion pulses and a pipeline stall.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd_en,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_type,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_type,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_reg, state_next;
  grant_t            last_grant_reg, last_grant_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [2:0]        mem_type_reg, mem_type_next;
  logic              if_ack_reg, if_ack_next;
  logic              d_ack_reg, d_ack_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

  logic              data_pend;
  logic              grant_data;
  logic              grant_fetch;
  logic              on_bus;
  logic              timer_clear;
  logic              timer_en;
  logic              timer_expire;
  logic [WAIT_W-1:0] wait_count;

  // Simultaneous read and write enables fall into the data path as a store.
  assign data_pend   = d_rd_en | d_wr_en;
  // On a tie the side that did not win last time goes first.
  assign grant_data  = data_pend & (~if_req | (last_grant_reg == G_FETCH));
  assign grant_fetch = if_req & ~grant_data;
  assign on_bus      = (state_reg == FETCH) || (state_reg == DATA);
  assign timer_clear = (state_reg == IDLE) & (if_req | data_pend);
  // Holding enable off at saturation keeps the counter from ever wrapping.
  assign timer_en    = on_bus & ~mem_ack & (wait_count != '1);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .CLK    (CLK),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .count  (wait_count),
    .expire (timer_expire)
  );

  // Next-state, grant capture and completion pulse generation.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    mem_type_next   = mem_type_reg;
    if_ack_next     = 1'b0;
    d_ack_next      = 1'b0;
    err_next        = 1'b0;
    if_rdata_next   = '0;
    d_rdata_next    = '0;
    case (state_reg)
      IDLE: begin
        if (grant_data) begin
          state_next      = DATA;
          last_grant_next = G_DATA;
          mem_req_next    = 1'b1;
          mem_we_next     = d_wr_en;
          mem_addr_next   = d_addr;
          mem_wdata_next  = d_wdata;
          mem_type_next   = d_type;
        end else if (grant_fetch) begin
          last_grant_next = G_FETCH;
          mem_we_next     = 1'b0;
          mem_addr_next   = if_addr;
          mem_wdata_next  = '0;
          mem_type_next   = XFER_WORD;
          if (if_addr[1:0] != 2'b00) begin
            // Misaligned fetch never reaches the bus; reject it straight away.
            state_next  = RESP;
            if_ack_next = 1'b1;
            err_next    = 1'b1;
          end else begin
            state_next   = FETCH;
            mem_req_next = 1'b1;
          end
        end
      end
      FETCH, DATA: begin
        if (mem_ack) begin
          // An ack on the final allowed cycle still counts as success.
          state_next   = RESP;
          mem_req_next = 1'b0;
          if (state_reg == FETCH) begin
            if_ack_next   = 1'b1;
            if_rdata_next = mem_rdata;
          end else begin
            d_ack_next   = 1'b1;
            d_rdata_next = mem_rdata;
          end
        end else if (timer_expire) begin
          state_next   = RESP;
          mem_req_next = 1'b0;
          err_next     = 1'b1;
          if (state_reg == FETCH) begin
            if_ack_next = 1'b1;
          end else begin
            d_ack_next = 1'b1;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, bus fields and response registers; reset drops mem_req at once.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= G_FETCH;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_type_reg   <= '0;
      if_ack_reg     <= 1'b0;
      d_ack_reg      <= 1'b0;
      err_reg        <= 1'b0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_type_reg   <= mem_type_next;
      if_ack_reg     <= if_ack_next;
      d_ack_reg      <= d_ack_next;
      err_reg        <= err_next;
      if_rdata_reg   <= if_rdata_next;
      d_rdata_reg    <= d_rdata_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_type  = mem_type_reg;
  assign if_ack    = if_ack_reg;
  assign d_ack     = d_ack_reg;
  assign err       = err_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

  // A requester stalls the core until its own registered ack appears.
  assign cpu_stall = (if_req & ~if_ack_reg) | (data_pend & ~d_ack_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level model of grants and responses.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_rd_en = 1'b0;
  logic          d_wr_en = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [2:0]    d_type = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          cpu_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_type;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass = 0;
  // Model of round-robin history: 1 when the most recent grant went to data.
  bit model_last_data = 1'b0;

  mem_port_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_rd_en   (d_rd_en),
    .d_wr_en   (d_wr_en),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_type    (d_type),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .err       (err),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_type  (mem_type),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    if_req = 1'b0;
    d_rd_en = 1'b0;
    d_wr_en = 1'b0;
    mem_ack = 1'b0;
    step();
    step();
    rst = 1'b1;
    model_last_data = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++; if ({mem_req, mem_we, if_ack, d_ack, err, cpu_stall} !== 6'b0) $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, if_ack, d_ack, err, cpu_stall}); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== '0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
    n_checks++; if (mem_type !== 3'b000) $display("FAIL reset_mem_type: got %b want 000", mem_type); else n_pass++;
    n_checks++; if (if_rdata !== '0) $display("FAIL reset_if_rdata: got %h want 0", if_rdata); else n_pass++;
    n_checks++; if (d_rdata !== '0) $display("FAIL reset_d_rdata: got %h want 0", d_rdata); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++; if ({mem_req, if_ack, d_ack, err} !== 4'b0) $display("FAIL reset_release_idle: got %b want 0000", {mem_req, if_ack, d_ack, err}); else n_pass++;
    $display("txn reset: outputs inspected");
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1;
    if_addr = 32'h0000_0100;
    #1;
    n_checks++; if (cpu_stall !== 1'b1) $display("FAIL fetch_stall c0: got %b want 1", cpu_stall); else n_pass++;
    model_last_data = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_checks++; if (mem_req !== 1'b1) $display("FAIL fetch_req c%0d: got %b want 1", c, mem_req); else n_pass++;
      n_checks++; if ({mem_we, mem_type, mem_addr} !== {1'b0, 3'b010, 32'h100}) $display("FAIL fetch_fields c%0d: got we=%b type=%b addr=%h want 0/010/00000100", c, mem_we, mem_type, mem_addr); else n_pass++;
      n_checks++; if ({if_ack, cpu_stall} !== 2'b01) $display("FAIL fetch_wait c%0d: got ack=%b stall=%b want 0/1", c, if_ack, cpu_stall); else n_pass++;
      if (c == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h0050_0093;
      end
    end
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    n_checks++; if ({if_ack, err, mem_req, cpu_stall} !== 4'b1000) $display("FAIL fetch_resp c4: got ack/err/req/stall=%b want 1000", {if_ack, err, mem_req, cpu_stall}); else n_pass++;
    n_checks++; if (if_rdata !== 32'h0050_0093) $display("FAIL fetch_rdata c4: got %h want 00500093", if_rdata); else n_pass++;
    if_req = 1'b0;
    step();
    n_checks++; if ({if_ack, mem_req} !== 2'b00) $display("FAIL fetch_after c5: got ack/req=%b want 00", {if_ack, mem_req}); else n_pass++;
    $display("txn single_fetch: addr=00000100");
  endtask

  task automatic test_min_fetch();
    int stall_cycles = 0;
    if_req = 1'b1;
    if_addr = 32'h0000_0200;
    model_last_data = 1'b0;
    #1;
    if (cpu_stall === 1'b1) stall_cycles++;
    step();
    if (cpu_stall === 1'b1) stall_cycles++;
    n_checks++; if (mem_req !== 1'b1) $display("FAIL minfetch_req: got %b want 1", mem_req); else n_pass++;
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    if (cpu_stall === 1'b1) stall_cycles++;
    n_checks++; if ({if_ack, if_rdata} !== {1'b1, 32'h1234_5678}) $display("FAIL minfetch_ack: got ack=%b data=%h want 1/12345678", if_ack, if_rdata); else n_pass++;
    n_checks++; if (stall_cycles != 2) $display("FAIL minfetch_stall_len: got %0d want 2", stall_cycles); else n_pass++;
    if_req = 1'b0;
    step();
    $display("txn min_fetch: stall_cycles=%0d", stall_cycles);
  endtask

  task automatic test_store();
    d_wr_en = 1'b1;
    d_addr = 32'h0000_2004;
    d_wdata = 32'hDEAD_BEEF;
    d_type = 3'b001;
    model_last_data = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      step();
      n_checks++; if ({mem_req, mem_we, mem_type} !== 5'b11001) $display("FAIL store_ctrl c%0d: got req/we/type=%b want 11001", c, {mem_req, mem_we, mem_type}); else n_pass++;
      n_checks++; if ({mem_addr, mem_wdata} !== {32'h2004, 32'hDEADBEEF}) $display("FAIL store_data c%0d: got %h/%h want 00002004/deadbeef", c, mem_addr, mem_wdata); else n_pass++;
      // Scramble the requester fields; the latched bus fields must not move.
      d_addr = 32'hAAAA_0000;
      d_wdata = 32'h5555_5555;
      d_type = 3'b111;
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_checks++; if ({d_ack, err, if_ack, mem_req} !== 4'b1000) $display("FAIL store_resp: got dack/err/iack/req=%b want 1000", {d_ack, err, if_ack, mem_req}); else n_pass++;
    d_wr_en = 1'b0;
    step();
    $display("txn store: addr=00002004 data=deadbeef");
  endtask

  task automatic test_timeout();
    d_rd_en = 1'b1;
    d_addr = 32'h0000_3000;
    d_type = 3'b010;
    model_last_data = 1'b1;
    step();
    for (int k = 0; k < TO; k++) begin
      n_checks++; if ({mem_req, d_ack} !== 2'b10) $display("FAIL timeout_wait k%0d: got req/ack=%b want 10", k, {mem_req, d_ack}); else n_pass++;
      mem_rdata = $urandom();
      step();
    end
    n_checks++; if ({mem_req, d_ack, err} !== 3'b011) $display("FAIL timeout_abort: got req/ack/err=%b want 011", {mem_req, d_ack, err}); else n_pass++;
    n_checks++; if (d_rdata !== '0) $display("FAIL timeout_rdata: got %h want 0", d_rdata); else n_pass++;
    d_rd_en = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_checks++; if ({d_ack, if_ack, err, mem_req} !== 4'b0) $display("FAIL late_ack_resp: got %b want 0000", {d_ack, if_ack, err, mem_req}); else n_pass++;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_checks++; if ({d_ack, if_ack, err, mem_req} !== 4'b0) $display("FAIL late_ack_idle: got %b want 0000", {d_ack, if_ack, err, mem_req}); else n_pass++;
    $display("txn timeout: addr=00003000 aborted");
    // Ack on the last cycle before the limit is still a success.
    d_rd_en = 1'b1;
    d_addr = 32'h0000_3004;
    step();
    for (int k = 0; k < TO; k++) begin
      n_checks++; if (mem_req !== 1'b1) $display("FAIL edge_wait k%0d: got %b want 1", k, mem_req); else n_pass++;
      if (k == TO - 1) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_0001;
      end
      step();
    end
    mem_ack = 1'b0;
    n_checks++; if ({d_ack, err, d_rdata} !== {2'b10, 32'hCAFE0001}) $display("FAIL edge_ack: got ack=%b err=%b data=%h want 1/0/cafe0001", d_ack, err, d_rdata); else n_pass++;
    d_rd_en = 1'b0;
    step();
    $display("txn timeout_edge: addr=00003004 acked on last cycle");
  endtask

  task automatic test_misaligned();
    if_req = 1'b1;
    if_addr = 32'h0000_0102;
    mem_rdata = 32'h7777_7777;
    model_last_data = 1'b0;
    step();
    n_checks++; if ({mem_req, if_ack, err} !== 3'b011) $display("FAIL misalign_resp: got req/ack/err=%b want 011", {mem_req, if_ack, err}); else n_pass++;
    n_checks++; if (if_rdata !== '0) $display("FAIL misalign_rdata: got %h want 0", if_rdata); else n_pass++;
    if_req = 1'b0;
    step();
    n_checks++; if ({mem_req, if_ack, err} !== 3'b000) $display("FAIL misalign_after: got %b want 000", {mem_req, if_ack, err}); else n_pass++;
    $display("txn misaligned: addr=00000102 rejected");
  endtask

  task automatic test_contention();
    bit exp_data;
    string seq = "";
    apply_reset();
    if_req = 1'b1;
    if_addr = 32'h0000_0400;
    d_rd_en = 1'b1;
    d_addr = 32'h0000_0800;
    d_type = 3'b000;
    for (int g = 0; g < 4; g++) begin
      exp_data = !model_last_data;
      model_last_data = exp_data;
      step();
      n_checks++; if ({mem_req, mem_addr} !== {1'b1, exp_data ? 32'h800 : 32'h400}) $display("FAIL contention_grant g%0d: got req=%b addr=%h want data=%b", g, mem_req, mem_addr, exp_data); else n_pass++;
      n_checks++; if (mem_type !== (exp_data ? 3'b000 : 3'b010)) $display("FAIL contention_type g%0d: got %b", g, mem_type); else n_pass++;
      mem_ack = 1'b1;
      mem_rdata = 32'h1000 + g;
      step();
      mem_ack = 1'b0;
      n_checks++; if ({if_ack, d_ack} !== {!exp_data, exp_data}) $display("FAIL contention_ack g%0d: got if/d=%b%b want %b%b", g, if_ack, d_ack, !exp_data, exp_data); else n_pass++;
      seq = {seq, exp_data ? "D" : "F"};
      step();
    end
    if_req = 1'b0;
    d_rd_en = 1'b0;
    step();
    $display("txn contention: grants %s", seq);
  endtask

  task automatic test_reset_mid();
    d_rd_en = 1'b1;
    d_addr = 32'h0000_0900;
    model_last_data = 1'b1;
    step();
    step();
    n_checks++; if (mem_req !== 1'b1) $display("FAIL midrst_busy: got %b want 1", mem_req); else n_pass++;
    rst = 1'b0;
    d_rd_en = 1'b0;
    mem_ack = 1'b1;
    model_last_data = 1'b0;
    #1;
    n_checks++; if ({mem_req, mem_we, if_ack, d_ack, err, cpu_stall, mem_addr} !== '0) $display("FAIL midrst_async: got req=%b addr=%h", mem_req, mem_addr); else n_pass++;
    step();
    rst = 1'b1;
    step();
    mem_ack = 1'b0;
    n_checks++; if ({mem_req, d_ack, if_ack, err} !== 4'b0) $display("FAIL midrst_stale_ack: got %b want 0000", {mem_req, d_ack, if_ack, err}); else n_pass++;
    if_req = 1'b1;
    if_addr = 32'h0000_0500;
    d_rd_en = 1'b1;
    d_addr = 32'h0000_0904;
    step();
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h904}) $display("FAIL midrst_tie: got req=%b addr=%h want 1/00000904", mem_req, mem_addr); else n_pass++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    d_rd_en = 1'b0;
    n_checks++; if (d_ack !== 1'b1) $display("FAIL midrst_dack: got %b want 1", d_ack); else n_pass++;
    step();
    step();
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h500}) $display("FAIL midrst_fetch: got req=%b addr=%h want 1/00000500", mem_req, mem_addr); else n_pass++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    if_req = 1'b0;
    step();
    model_last_data = 1'b0;
    $display("txn reset_mid: tie after release went to data");
  endtask

  task automatic test_random();
    bit f_pend = 1'b0;
    bit d_pend = 1'b0;
    bit f_mis = 1'b0;
    bit d_we = 1'b0;
    bit d_both = 1'b0;
    logic [31:0] f_addr_v = '0;
    logic [31:0] d_addr_v = '0;
    logic [31:0] d_wdata_v = '0;
    logic [2:0] d_type_v = '0;
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
    bit data_win;
    bit exp_err;
    bit exp_we;
    bit exp_if_ack;
    bit exp_d_ack;
    bit exp_stall;
    logic [2:0] exp_type;
    int w;
    for (int t = 0; t < 40; t++) begin
      if (!f_pend && ($urandom_range(0, 2) != 0)) begin
        f_pend = 1'b1;
        f_mis = ($urandom_range(0, 7) == 0);
        f_addr_v = $urandom() & 32'hFFFF_FFFC;
        if (f_mis) f_addr_v[1:0] = 2'($urandom_range(1, 3));
        if_req = 1'b1;
        if_addr = f_addr_v;
      end
      if (!d_pend && (!f_pend || ($urandom_range(0, 2) != 0))) begin
        d_pend = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_both = ($urandom_range(0, 7) == 0);
        d_addr_v = $urandom();
        d_wdata_v = $urandom();
        d_type_v = 3'($urandom_range(0, 7));
        d_rd_en = !d_we || d_both;
        d_wr_en = d_we || d_both;
        d_addr = d_addr_v;
        d_wdata = d_wdata_v;
        d_type = d_type_v;
        if (d_both) d_we = 1'b1;
      end
      #1;
      n_checks++; if (cpu_stall !== 1'b1) $display("FAIL rand_stall_req t%0d: got %b want 1", t, cpu_stall); else n_pass++;
      data_win = d_pend && (!f_pend || !model_last_data);
      model_last_data = data_win;
      exp_addr = data_win ? d_addr_v : f_addr_v;
      exp_we = data_win ? d_we : 1'b0;
      exp_type = data_win ? d_type_v : 3'b010;
      w = $urandom_range(0, 5);
      rd = $urandom();
      step();
      if (!data_win && f_mis) begin
        exp_err = 1'b1;
      end else begin
        exp_err = (w >= TO);
        for (int k = 0; k < TO; k++) begin
          n_checks++; if ({mem_req, if_ack, d_ack} !== 3'b100) $display("FAIL rand_bus t%0d k%0d: got req/iack/dack=%b want 100", t, k, {mem_req, if_ack, d_ack}); else n_pass++;
          n_checks++; if ({mem_addr, mem_we, mem_type} !== {exp_addr, exp_we, exp_type}) $display("FAIL rand_fields t%0d k%0d: got %h/%b/%b want %h/%b/%b", t, k, mem_addr, mem_we, mem_type, exp_addr, exp_we, exp_type); else n_pass++;
          if (data_win && d_we) begin
            n_checks++; if (mem_wdata !== d_wdata_v) $display("FAIL rand_wdata t%0d k%0d: got %h want %h", t, k, mem_wdata, d_wdata_v); else n_pass++;
          end
          if (data_win) begin
            d_addr = $urandom();
            d_wdata = $urandom();
            d_type = 3'($urandom_range(0, 7));
          end else begin
            if_addr = $urandom();
          end
          if (k == 0 && $urandom_range(0, 3) == 0) begin
            if (data_win) begin
              d_rd_en = 1'b0;
              d_wr_en = 1'b0;
              d_pend = 1'b0;
            end else begin
              if_req = 1'b0;
              f_pend = 1'b0;
            end
          end
          if (k == w) begin
            mem_ack = 1'b1;
            mem_rdata = rd;
            step();
            mem_ack = 1'b0;
            mem_rdata = $urandom();
            break;
          end
          mem_rdata = $urandom();
          step();
        end
      end
      exp_rd = exp_err ? 32'h0 : rd;
      exp_if_ack = !data_win;
      exp_d_ack = data_win;
      exp_stall = (if_req && !exp_if_ack) || ((d_rd_en || d_wr_en) && !exp_d_ack);
      n_checks++; if ({if_ack, d_ack, err, mem_req} !== {exp_if_ack, exp_d_ack, exp_err, 1'b0}) $display("FAIL rand_resp t%0d: got iack/dack/err/req=%b want %b%b%b0", t, {if_ack, d_ack, err, mem_req}, exp_if_ack, exp_d_ack, exp_err); else n_pass++;
      n_checks++; if (cpu_stall !== exp_stall) $display("FAIL rand_stall_resp t%0d: got %b want %b", t, cpu_stall, exp_stall); else n_pass++;
      if (!data_win) begin
        n_checks++; if (if_rdata !== exp_rd) $display("FAIL rand_if_rdata t%0d: got %h want %h", t, if_rdata, exp_rd); else n_pass++;
      end else if (!d_we) begin
        n_checks++; if (d_rdata !== exp_rd) $display("FAIL rand_d_rdata t%0d: got %h want %h", t, d_rdata, exp_rd); else n_pass++;
      end
      $display("txn %0d: %s addr=%h waits=%0d err=%0b", t, data_win ? (d_we ? "store" : "load ") : "fetch", exp_addr, w, exp_err);
      if (data_win) begin
        d_rd_en = 1'b0;
        d_wr_en = 1'b0;
        d_pend = 1'b0;
      end else begin
        if_req = 1'b0;
        f_pend = 1'b0;
      end
      step();
    end
    if_req = 1'b0;
    d_rd_en = 1'b0;
    d_wr_en = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_min_fetch();
    test_store();
    test_timeout();
    test_misaligned();
    test_contention();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
